// File: rtl/quad_pkg.sv
// quad_pkg: quadrature state encodings and the step decode shared by the decoder
package quad_pkg;
   localparam logic [1:0] ST_00 = 2'b00;
   localparam logic [1:0] ST_10 = 2'b10;
   localparam logic [1:0] ST_11 = 2'b11;
   localparam logic [1:0] ST_01 = 2'b01;

   // {valid, up}: valid when exactly one phase changed, up when cur follows prev in the A-leads-B order
   function automatic logic [1:0] step_dec(input logic [1:0] p, input logic [1:0] c);
      logic [1:0] up_nxt;
      up_nxt = (p == ST_00) ? ST_10 : (p == ST_10) ? ST_11 : (p == ST_11) ? ST_01 : ST_00;
      return {^(p ^ c), c == up_nxt};
   endfunction
endpackage

// File: rtl/quad_filter.sv
// quad_filter: synchronizer chain plus persistence filter for one encoder phase
module quad_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d_i,
   output logic sync_o,
   output logic acc_o
);
   localparam int CW = $clog2(FILT_LEN + 1);
   localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic acc_q, acc_d;

   assign sync_o = sync_q[SYNC_STAGES-1];
   assign acc_o  = acc_q;

   // shift the raw input in; count cycles of disagreement and accept on the FILT_LEN-th one
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
      cnt_d  = (sync_o != acc_q && cnt_q != LAST) ? cnt_q + 1'b1 : '0;
      acc_d  = (sync_o != acc_q && cnt_q == LAST) ? sync_o : acc_q;
   end

   // state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         cnt_q  <= '0;
         acc_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
      end
   end
endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: x4 quadrature decoder with priming, step/dir events and wrapping position count
module quad_decoder
   import quad_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             qa,
   input  logic             qb,
   input  logic             clr,
   input  logic             err_clr,
   output logic [WIDTH-1:0] count,
   output logic             dir,
   output logic             step,
   output logic             err,
   output logic             primed
);
   localparam int SW = $clog2(FILT_LEN + 1);
   localparam logic [SW-1:0] LAST = SW'(FILT_LEN - 1);

   logic a_sync, b_sync, a_acc, b_acc;
   logic [1:0] pair, cur, dec;
   logic [1:0] prev_q, prev_d, pair_q, pair_d;
   logic [SW-1:0] stab_q, stab_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic primed_q, primed_d, dir_q, dir_d, step_q, step_d, err_q, err_d;

   quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_fa (
      .clk(clk), .reset_n(reset_n), .d_i(qa), .sync_o(a_sync), .acc_o(a_acc)
   );
   quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_fb (
      .clk(clk), .reset_n(reset_n), .d_i(qb), .sync_o(b_sync), .acc_o(b_acc)
   );

   assign pair   = {a_sync, b_sync};
   assign cur    = {a_acc, b_acc};
   assign count  = count_q;
   assign dir    = dir_q;
   assign step   = step_q;
   assign err    = err_q;
   assign primed = primed_q;

   // prev tracks the accepted state continuously so it already holds the captured state when priming completes
   always_comb begin
      dec      = step_dec(prev_q, cur);
      pair_d   = pair;
      prev_d   = cur;
      stab_d   = (pair == pair_q) ? ((stab_q == LAST) ? stab_q : stab_q + 1'b1) : '0;
      primed_d = primed_q | (pair == pair_q && stab_q == LAST);
      step_d   = primed_q & dec[1];
      dir_d    = step_d ? dec[0] : dir_q;
      count_d  = clr ? '0 : step_d ? (dec[0] ? count_q + 1'b1 : count_q - 1'b1) : count_q;
      err_d    = (primed_q && (prev_q ^ cur) == 2'b11) ? 1'b1 : err_clr ? 1'b0 : err_q;
   end

   // state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q   <= ST_00;
         pair_q   <= ST_00;
         stab_q   <= '0;
         primed_q <= 1'b0;
         count_q  <= '0;
         dir_q    <= 1'b0;
         step_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         prev_q   <= prev_d;
         pair_q   <= pair_d;
         stab_q   <= stab_d;
         primed_q <= primed_d;
         count_q  <= count_d;
         dir_q    <= dir_d;
         step_q   <= step_d;
         err_q    <= err_d;
      end
   end
endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: directed scenario tests for quad_decoder at default parameters
module tb_quad_decoder;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic qa = 1'b0, qb = 1'b0, clr = 1'b0, err_clr = 1'b0;
   logic [15:0] count;
   logic dir, step, err, primed;
   int vectors = 0;
   int miscompares = 0;

   quad_decoder dut (
      .clk(clk), .reset_n(reset_n), .qa(qa), .qb(qb), .clr(clr), .err_clr(err_clr),
      .count(count), .dir(dir), .step(step), .err(err), .primed(primed)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] ab, input int hold, output int steps, output int first);
      {qa, qb} = ab;
      steps = 0;
      first = 0;
      for (int i = 1; i <= hold; i++) begin
         tick();
         if (step) begin
            steps++;
            if (first == 0) first = i;
         end
      end
   endtask

   task automatic restart(input logic [1:0] ab);
      int s, f;
      reset_n = 1'b0;
      {qa, qb} = ab;
      tick();
      tick();
      reset_n = 1'b1;
      drive(ab, 12, s, f);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      vectors++;
      if ({count, dir, step, err, primed} !== 20'h0) begin
         miscompares++;
         $display("FAIL reset: count=%h dir=%b step=%b err=%b primed=%b, want all 0", count, dir, step, err, primed);
      end
   endtask

   task automatic test_prime();
      int s, f;
      reset_n = 1'b1;
      drive(2'b11, 20, s, f);
      vectors++;
      if (primed !== 1'b1 || count !== 16'h0 || s != 0 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL prime: primed=%b count=%h steps=%0d err=%b, want 1 0000 0 0", primed, count, s, err);
      end
   endtask

   task automatic test_forward();
      logic [1:0] seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
      int s, f;
      restart(2'b00);
      for (int i = 0; i < 4; i++) begin
         drive(seq[i], 10, s, f);
         vectors++;
         if (s != 1 || f != 7 || count !== 16'(i + 1) || dir !== 1'b1) begin
            miscompares++;
            $display("FAIL forward[%0d]: steps=%0d at=%0d count=%h dir=%b, want 1 7 %h 1", i, s, f, count, dir, 16'(i + 1));
         end
      end
   endtask

   task automatic test_reverse_wrap();
      logic [1:0] seq [3] = '{2'b01, 2'b11, 2'b10};
      logic [15:0] exp [3] = '{16'hFFFF, 16'hFFFE, 16'hFFFD};
      int s, f;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      vectors++;
      if (count !== 16'h0) begin
         miscompares++;
         $display("FAIL clr_idle: count=%h, want 0000", count);
      end
      for (int i = 0; i < 3; i++) begin
         drive(seq[i], 10, s, f);
         vectors++;
         if (s != 1 || f != 7 || count !== exp[i] || dir !== 1'b0) begin
            miscompares++;
            $display("FAIL reverse[%0d]: steps=%0d at=%0d count=%h dir=%b, want 1 7 %h 0", i, s, f, count, dir, exp[i]);
         end
      end
   endtask

   task automatic test_glitch();
      int s, f;
      drive(2'b00, 10, s, f);
      vectors++;
      if (s != 1 || count !== 16'hFFFC || dir !== 1'b0) begin
         miscompares++;
         $display("FAIL glitch_setup: steps=%0d count=%h dir=%b, want 1 fffc 0", s, count, dir);
      end
      qa = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      drive(2'b00, 12, s, f);
      vectors++;
      if (s != 0 || count !== 16'hFFFC) begin
         miscompares++;
         $display("FAIL glitch3: steps=%0d count=%h, want 0 fffc", s, count);
      end
      qa = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      drive(2'b00, 14, s, f);
      vectors++;
      if (s != 2 || count !== 16'hFFFC || dir !== 1'b0) begin
         miscompares++;
         $display("FAIL glitch4: steps=%0d count=%h dir=%b, want 2 fffc 0", s, count, dir);
      end
   endtask

   task automatic test_illegal();
      int s, f;
      drive(2'b11, 10, s, f);
      vectors++;
      if (s != 0 || err !== 1'b1 || count !== 16'hFFFC) begin
         miscompares++;
         $display("FAIL illegal: steps=%0d err=%b count=%h, want 0 1 fffc", s, err, count);
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      vectors++;
      if (err !== 1'b0) begin
         miscompares++;
         $display("FAIL err_clr: err=%b, want 0", err);
      end
      {qa, qb} = 2'b00;
      for (int i = 0; i < 6; i++) tick();
      vectors++;
      if (err !== 1'b0) begin
         miscompares++;
         $display("FAIL illegal_early: err=%b, want 0", err);
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      vectors++;
      if (err !== 1'b1 || step !== 1'b0 || count !== 16'hFFFC) begin
         miscompares++;
         $display("FAIL set_wins: err=%b step=%b count=%h, want 1 0 fffc", err, step, count);
      end
      drive(2'b00, 4, s, f);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
   endtask

   task automatic test_clear_on_step();
      qa = 1'b1;
      qb = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      vectors++;
      if (step !== 1'b1 || count !== 16'h0 || dir !== 1'b1) begin
         miscompares++;
         $display("FAIL clr_step: step=%b count=%h dir=%b, want 1 0000 1", step, count, dir);
      end
      tick();
      vectors++;
      if (step !== 1'b0 || count !== 16'h0) begin
         miscompares++;
         $display("FAIL clr_after: step=%b count=%h, want 0 0000", step, count);
      end
   endtask

   task automatic test_reset_mid();
      int s, f;
      drive(2'b11, 10, s, f);
      vectors++;
      if (count !== 16'h1 || primed !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_reset: count=%h primed=%b, want 0001 1", count, primed);
      end
      drive(2'b01, 3, s, f);
      reset_n = 1'b0;
      #1;
      vectors++;
      if ({count, dir, step, err, primed} !== 20'h0) begin
         miscompares++;
         $display("FAIL reset_mid: count=%h dir=%b step=%b err=%b primed=%b, want all 0", count, dir, step, err, primed);
      end
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      tick();
      vectors++;
      if (primed !== 1'b0) begin
         miscompares++;
         $display("FAIL reprime_early: primed=%b, want 0", primed);
      end
      drive(2'b01, 20, s, f);
      vectors++;
      if (primed !== 1'b1 || s != 0 || count !== 16'h0 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL reprime: primed=%b steps=%0d count=%h err=%b, want 1 0 0000 0", primed, s, count, err);
      end
   endtask

   task automatic test_wrap_up();
      int s, f;
      drive(2'b11, 10, s, f);
      vectors++;
      if (s != 1 || count !== 16'hFFFF || dir !== 1'b0) begin
         miscompares++;
         $display("FAIL wrap_down: steps=%0d count=%h dir=%b, want 1 ffff 0", s, count, dir);
      end
      drive(2'b01, 10, s, f);
      vectors++;
      if (s != 1 || count !== 16'h0 || dir !== 1'b1) begin
         miscompares++;
         $display("FAIL wrap_up: steps=%0d count=%h dir=%b, want 1 0000 1", s, count, dir);
      end
   endtask

   initial begin
      test_reset();
      test_prime();
      test_forward();
      test_reverse_wrap();
      test_glitch();
      test_illegal();
      test_clear_on_step();
      test_reset_mid();
      test_wrap_up();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
